wb_single_master_engine: RTL and testbench

- Single-outstanding Wishbone B4 classic master engine, driven by a simple valid/ready request port and returning a one-cycle response pulse.
- Sits between a testbench or host-side command source and a Wishbone slave or interconnect.
- Issues exactly one registered bus cycle per accepted request and captures read data on termination.

---
 rtl/wb_single_master_engine_if.sv | 32 +++
 rtl/wb_single_master_engine.sv | 157 +++++++++++++++
 tb/tb_wb_single_master_engine.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_single_master_engine_if.sv
// wb_single_master_engine_if
// Wishbone B4 classic bus bundle between the single-master engine and a slave
// or interconnect.
//   wb_adr, wb_cti, wb_bte, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb : master -> slave
//   wb_dat_r, wb_ack, wb_err                                        : slave -> master
// Modports: master (engine side), slave (target side).
interface wb_single_master_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   wb_adr;
  logic [2:0]              wb_cti;
  logic [1:0]              wb_bte;
  logic [DATA_WIDTH/8-1:0] wb_sel;
  logic                    wb_we;
  logic [DATA_WIDTH-1:0]   wb_dat_w;
  logic                    wb_cyc;
  logic                    wb_stb;
  logic [DATA_WIDTH-1:0]   wb_dat_r;
  logic                    wb_ack;
  logic                    wb_err;

  modport master (
    output wb_adr, wb_cti, wb_bte, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb,
    input  wb_dat_r, wb_ack, wb_err
  );

  modport slave (
    input  wb_adr, wb_cti, wb_bte, wb_sel, wb_we, wb_dat_w, wb_cyc, wb_stb,
    output wb_dat_r, wb_ack, wb_err
  );
endinterface

// File: rtl/wb_single_master_engine.sv
// wb_single_master_engine
// Single-outstanding Wishbone B4 classic master. A request accepted on the
// valid/ready port becomes exactly one registered bus cycle; termination
// (ack or err) produces a one-cycle rsp_valid pulse, with read data captured.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   req_valid/req_ready  request handshake (ready = IDLE and out of reset)
//   req_addr/cti/bte/sel/we/wdata  request fields, sampled only at acceptance
//   rsp_valid, rsp_err   one-cycle completion pulse and its error flag
//   rsp_rdata            last captured read data
//   bus                  Wishbone master modport (all outputs registered)
//
// Optional feature macro: WBM_TIMEOUT_EN
//   When defined, a bus cycle waiting TIMEOUT_CYCLES cycles without ack/err is
//   terminated as an error. When undefined, BUSY waits indefinitely.
module wb_single_master_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2:0]              req_cti,
  input  logic [1:0]              req_bte,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic                    req_we,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  wb_single_master_engine_if.master bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state;
  logic                    reset_done;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [2:0]              cti_q;
  logic [1:0]              bte_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   dat_w_q;
  logic                    cyc_q;
  logic                    stb_q;

  logic                    bus_term;
  logic                    timeout_hit;

  assign bus.wb_adr   = adr_q;
  assign bus.wb_cti   = cti_q;
  assign bus.wb_bte   = bte_q;
  assign bus.wb_sel   = sel_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_dat_w = dat_w_q;
  assign bus.wb_cyc   = cyc_q;
  assign bus.wb_stb   = stb_q;

  // Ready depends only on state so a source may legally wait for ready
  // before raising valid.
  assign req_ready = (state == IDLE) && reset_done;

  assign bus_term = bus.wb_ack || bus.wb_err;

`ifdef WBM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] timeout_cnt;

  // The counter holds the number of BUSY cycles already passed without
  // termination, so reaching TIMEOUT_LAST means this is the final allowed one.
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
`else
  logic unused_timeout_param;

  assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
  assign timeout_hit          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      reset_done <= 1'b0;
      adr_q      <= '0;
      cti_q      <= '0;
      bte_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      dat_w_q    <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
`ifdef WBM_TIMEOUT_EN
      timeout_cnt <= '0;
`endif
    end else begin
      reset_done <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state   <= BUSY;
            adr_q   <= req_addr;
            cti_q   <= req_cti;
            bte_q   <= req_bte;
            sel_q   <= req_sel;
            we_q    <= req_we;
            dat_w_q <= req_we ? req_wdata : '0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
`ifdef WBM_TIMEOUT_EN
            timeout_cnt <= '0;
`endif
          end
        end

        BUSY: begin
          if (bus_term || timeout_hit) begin
            state     <= IDLE;
            adr_q     <= '0;
            cti_q     <= '0;
            bte_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            dat_w_q   <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            rsp_valid <= 1'b1;
            // A real termination wins over a simultaneous timeout; a timeout
            // alone (no ack) is always reported as an error.
            rsp_err   <= bus.wb_err || !bus.wb_ack;
            if (bus_term && !we_q) begin
              rsp_rdata <= bus.wb_dat_r;
            end
          end
`ifdef WBM_TIMEOUT_EN
          else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_single_master_engine.sv
// tb_wb_single_master_engine
// Self-checking bench for wb_single_master_engine: a behavioural Wishbone slave,
// a bus-cycle monitor and a response scoreboard fed by applyStimulus.
// Define WBM_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
module tb_wb_single_master_engine;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_cti = '0;
  logic [1:0]    req_bte = '0;
  logic [3:0]    req_sel = '0;
  logic          req_we = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;

  wb_single_master_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_single_master_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_cti(req_cti), .req_bte(req_bte),
    .req_sel(req_sel), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_count = 0;
  int check_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
  endtask

  // Behavioural slave: terminates on the slave_delay-th cycle of a bus cycle.
  int            slave_delay = 1;
  bit            slave_ack_en = 1'b1;
  bit            slave_err = 1'b0;
  bit            idle_poke = 1'b0;
  logic [DW-1:0] slave_rdata = '0;
  int            slave_cnt = 0;

  always @(negedge clk) begin
    bus.wb_dat_r = slave_rdata;
    if (bus.wb_cyc === 1'b1 && bus.wb_stb === 1'b1) begin
      slave_cnt++;
      bus.wb_ack = slave_ack_en && (slave_cnt == slave_delay);
      bus.wb_err = slave_ack_en && slave_err && (slave_cnt == slave_delay);
    end else begin
      slave_cnt  = 0;
      bus.wb_ack = idle_poke;
      bus.wb_err = idle_poke;
    end
  end

  // Bus monitor: cycle lengths, gap before each cycle, first-cycle fields.
  int            cyc_len = 0, last_cyc_len = 0, gap_len = 0, last_gap = 0;
  logic [AW-1:0] seen_adr;
  logic [DW-1:0] seen_datw;
  logic [3:0]    seen_sel;
  logic [2:0]    seen_cti;
  logic [1:0]    seen_bte;
  logic          seen_we;
  bit            held_ok = 1'b1;

  always @(negedge clk) begin
    if (bus.wb_cyc === 1'b1) begin
      if (cyc_len == 0) begin
        seen_adr  = bus.wb_adr;
        seen_datw = bus.wb_dat_w;
        seen_sel  = bus.wb_sel;
        seen_cti  = bus.wb_cti;
        seen_bte  = bus.wb_bte;
        seen_we   = bus.wb_we;
        held_ok   = (bus.wb_stb === 1'b1);
        last_gap  = gap_len;
      end else if (bus.wb_adr !== seen_adr || bus.wb_dat_w !== seen_datw ||
                   bus.wb_sel !== seen_sel || bus.wb_we !== seen_we ||
                   bus.wb_stb !== 1'b1) begin
        held_ok = 1'b0;
      end
      cyc_len++;
      gap_len = 0;
    end else begin
      if (cyc_len != 0) last_cyc_len = cyc_len;
      cyc_len = 0;
      gap_len++;
    end
  end

  // Response scoreboard.
  logic          exp_err_q[$];
  logic [DW-1:0] exp_rdata_q[$];
  int            rsp_count = 0;
  bit            mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        if (exp_err_q.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          checkOutput("rsp_err", 64'(rsp_err), 64'(exp_err_q.pop_front()));
          checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata_q.pop_front()));
        end
      end else if (rsp_err !== 1'b0) begin
        checkOutput("rsp_err_idle", 64'(rsp_err), 64'd0);
      end
    end
  end

  logic [DW-1:0] model_rdata = '0;

  // Wait for ready, present one request for one accepting edge, then scramble
  // the request fields to show they are only sampled at acceptance.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic we, input logic [3:0] sel,
                               input logic [DW-1:0] wdata, input logic [2:0] cti, input logic [1:0] bte,
                               input bit push, input logic exp_err, input logic [DW-1:0] rd);
    int budget = 50;
    @(negedge clk);
    while (req_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checkOutput("ready_timeout", 64'(req_ready), 64'd1);
      return;
    end
    req_addr = addr; req_we = we; req_sel = sel; req_wdata = wdata;
    req_cti = cti; req_bte = bte; req_valid = 1'b1;
    if (push) begin
      if (!we && !(exp_err && !slave_ack_en)) model_rdata = rd;
      exp_err_q.push_back(exp_err);
      exp_rdata_q.push_back(model_rdata);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = ~addr; req_we = ~we; req_sel = ~sel; req_wdata = ~wdata;
    req_cti = ~cti; req_bte = ~bte;
  endtask

  task automatic waitRsp(input int target);
    int budget = 40;
    while (rsp_count < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (rsp_count < target) checkOutput("rsp_timeout", 64'(rsp_count), 64'(target));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 64'(req_ready), 64'd0);
    checkOutput("reset_cyc", 64'(bus.wb_cyc), 64'd0);
    checkOutput("reset_stb", 64'(bus.wb_stb), 64'd0);
    checkOutput("reset_adr", 64'(bus.wb_adr), 64'd0);
    checkOutput("reset_datw", 64'(bus.wb_dat_w), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_rdata", 64'(rsp_rdata), 64'd0);
    rstn = 1'b1;
    #1;
    checkOutput("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    checkOutput("ready_after_release", 64'(req_ready), 64'd1);
    mon_en = 1'b1;

    // Write, acked on the second bus cycle.
    slave_delay = 2; slave_err = 1'b0; slave_ack_en = 1'b1;
    base = rsp_count;
    applyStimulus(32'h28, 1'b1, 4'hF, 32'hDEADBEEF, 3'b111, 2'b00, 1'b1, 1'b0, '0);
    waitRsp(base + 1);
    checkOutput("wr_cyc_len", 64'(last_cyc_len), 64'd2);
    checkOutput("wr_adr", 64'(seen_adr), 64'h28);
    checkOutput("wr_datw", 64'(seen_datw), 64'hDEADBEEF);
    checkOutput("wr_we", 64'(seen_we), 64'd1);
    checkOutput("wr_cti", 64'(seen_cti), 64'd7);
    checkOutput("wr_held", 64'(held_ok), 64'd1);
    checkOutput("wr_ready_in_rsp", 64'(req_ready), 64'd1);
    @(negedge clk); #1;
    checkOutput("wr_single_pulse", 64'(rsp_count), 64'(base + 1));

    // Read with write data presented but suppressed, partial byte select.
    slave_delay = 1; slave_rdata = 32'h12345678;
    base = rsp_count;
    applyStimulus(32'h10, 1'b0, 4'h3, 32'hCAFEF00D, 3'b000, 2'b10, 1'b1, 1'b0, 32'h12345678);
    waitRsp(base + 1);
    checkOutput("rd_datw_zero", 64'(seen_datw), 64'd0);
    checkOutput("rd_sel", 64'(seen_sel), 64'h3);
    checkOutput("rd_adr", 64'(seen_adr), 64'h10);
    checkOutput("rd_bte", 64'(seen_bte), 64'd2);
    checkOutput("rd_cyc_len", 64'(last_cyc_len), 64'd1);

    // ack and err together on a read: error, but data still captured.
    slave_err = 1'b1; slave_rdata = 32'hA5A5A5A5;
    base = rsp_count;
    applyStimulus(32'h20, 1'b0, 4'hF, '0, 3'b000, 2'b00, 1'b1, 1'b1, 32'hA5A5A5A5);
    waitRsp(base + 1);
    checkOutput("err_cyc_low", 64'(bus.wb_cyc), 64'd0);
    checkOutput("err_stb_low", 64'(bus.wb_stb), 64'd0);
    checkOutput("err_adr_low", 64'(bus.wb_adr), 64'd0);
    checkOutput("err_sel_low", 64'(bus.wb_sel), 64'd0);
    slave_err = 1'b0;

    // Termination inputs while idle are ignored.
    base = rsp_count;
    idle_poke = 1'b1;
    repeat (3) @(negedge clk);
    idle_poke = 1'b0;
    @(negedge clk); #1;
    checkOutput("idle_ack_no_rsp", 64'(rsp_count), 64'(base));
    checkOutput("idle_ack_no_cyc", 64'(bus.wb_cyc), 64'd0);
    checkOutput("idle_ack_ready", 64'(req_ready), 64'd1);

    // Back-to-back: valid held high across two requests, immediate ack.
    slave_delay = 1; slave_rdata = 32'h0BADCAFE;
    base = rsp_count;
    @(negedge clk);
    req_addr = 32'h40; req_we = 1'b1; req_sel = 4'hF; req_wdata = 32'h11112222;
    req_cti = '0; req_bte = '0; req_valid = 1'b1;
    exp_err_q.push_back(1'b0); exp_rdata_q.push_back(model_rdata);
    @(posedge clk); #1;
    req_addr = 32'h44; req_we = 1'b0; req_sel = 4'hC; req_wdata = 32'h33334444;
    model_rdata = 32'h0BADCAFE;
    exp_err_q.push_back(1'b0); exp_rdata_q.push_back(model_rdata);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitRsp(base + 2);
    checkOutput("b2b_pulses", 64'(rsp_count - base), 64'd2);
    checkOutput("b2b_gap", 64'(last_gap), 64'd1);
    checkOutput("b2b_adr2", 64'(seen_adr), 64'h44);
    checkOutput("b2b_sel2", 64'(seen_sel), 64'hC);

    // Silent slave: timeout (if built) or indefinite wait.
    slave_ack_en = 1'b0;
    base = rsp_count;
`ifdef WBM_TIMEOUT_EN
    applyStimulus(32'h50, 1'b0, 4'hF, '0, 3'b000, 2'b00, 1'b1, 1'b1, '0);
    waitRsp(base + 1);
    checkOutput("to_cyc_len", 64'(last_cyc_len), 64'd4);
    checkOutput("to_cyc_low", 64'(bus.wb_cyc), 64'd0);
    base = rsp_count;
`endif
    // Reset while BUSY aborts the cycle with no response.
    applyStimulus(32'h60, 1'b0, 4'hF, '0, 3'b000, 2'b00, 1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    checkOutput("hang_cyc_high", 64'(bus.wb_cyc), 64'd1);
    rstn = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_cyc_low", 64'(bus.wb_cyc), 64'd0);
    checkOutput("abort_stb_low", 64'(bus.wb_stb), 64'd0);
    checkOutput("abort_no_rsp", 64'(rsp_count), 64'(base));
    checkOutput("abort_rdata_clr", 64'(rsp_rdata), 64'd0);
    rstn = 1'b1;
    model_rdata = '0;
    slave_ack_en = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("abort_ready", 64'(req_ready), 64'd1);
    checkOutput("sb_drained", 64'(exp_err_q.size()), 64'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
